// File: rtl/axil_bresp_arb.sv
// AXI-Lite write-response arbiter: round-robin merge of internal
// completion requesters onto one B channel, with wait and error tracking.
module axil_bresp_arb #(
  parameter int NREQ    = 4,
  parameter int MAXWAIT = 5
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_ARESETN,
  input  logic [NREQ-1:0]           REQ_VALID,
  input  logic [2*NREQ-1:0]         REQ_RESP,
  output logic [NREQ-1:0]           REQ_READY,
  output logic                      AXI_BVALID,
  output logic [1:0]                AXI_BRESP,
  input  logic                      AXI_BREADY,
  output logic [$clog2(NREQ)-1:0]   GRANT_ID,
  output logic                      WAIT_TIMEOUT,
  output logic [7:0]                SLVERR_CNT
);

  localparam int IW = $clog2(NREQ);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [7:0]        wait_q, wait_d;
  logic              to_q, to_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              hs;
  logic              free;
  logic              found;
  logic              grant;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     kk;
  logic [2*NREQ-1:0] rsh;
  logic [NREQ-1:0]   ready;

  assign hs   = (state_q == RESP) & AXI_BREADY;
  assign free = (state_q == IDLE) | hs;

  // first valid requester strictly after the last grant, wrapping
  always_comb begin
    found = 1'b0;
    idx   = '0;
    kk    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      kk = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && REQ_VALID[kk]) begin
        found = 1'b1;
        idx   = kk;
      end
    end
  end

  assign grant = free & found;
  assign rsh   = REQ_RESP >> {idx, 1'b0};

  always_comb begin
    ready = '0;
    if (grant) ready[idx] = 1'b1;
  end

  // the acceptance pulse must not leak out while reset is held
  assign REQ_READY = AXI_ARESETN ? ready : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    bresp_d = bresp_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    if (hs && bresp_q[1] && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
    if (grant) begin
      state_d = RESP;
      ptr_d   = idx;
      gid_d   = idx;
      bresp_d = rsh[1:0];
      wait_d  = '0;
    end else if (hs) begin
      state_d = IDLE;
    end else if (state_q == RESP && wait_q < 8'(MAXWAIT)) begin
      wait_d = wait_q + 8'd1;
    end
    to_d = to_q | (wait_d == 8'(MAXWAIT));
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      gid_q   <= '0;
      bresp_q <= 2'b00;
      wait_q  <= '0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      bresp_q <= bresp_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign AXI_BVALID   = (state_q == RESP);
  assign AXI_BRESP    = bresp_q;
  assign GRANT_ID     = gid_q;
  assign WAIT_TIMEOUT = to_q;
  assign SLVERR_CNT   = cnt_q;

endmodule

// File: tb/tb_axil_bresp_arb.sv
// Directed bench for axil_bresp_arb: vector table plus
// async-reset and counter-saturation sequences.
module tb_axil_bresp_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] valid = '0;
  logic [7:0] resp = '0;
  logic       bready = 1'b0;
  logic [3:0] ready;
  logic       bvalid;
  logic [1:0] bresp;
  logic [1:0] gid;
  logic       to;
  logic [7:0] cnt;

  int nvec = 0;
  int nerr = 0;

  axil_bresp_arb #(.NREQ(4), .MAXWAIT(5)) dut (
    .AXI_ACLK    (clk),
    .AXI_ARESETN (rst_n),
    .REQ_VALID   (valid),
    .REQ_RESP    (resp),
    .REQ_READY   (ready),
    .AXI_BVALID  (bvalid),
    .AXI_BRESP   (bresp),
    .AXI_BREADY  (bready),
    .GRANT_ID    (gid),
    .WAIT_TIMEOUT(to),
    .SLVERR_CNT  (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [7:0] r;
    logic       br;
    logic [3:0] e_rdy;
    logic       e_bv;
    logic [1:0] e_bresp;
    logic [1:0] e_gid;
    logic       e_to;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [29];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rs, input logic [3:0] v,
      input logic [7:0] r, input logic b, input logic [3:0] er,
      input logic ebv, input logic [1:0] ebr, input logic [1:0] eg,
      input logic eto, input logic [7:0] ec);
    vec_t t;
    t.rst = rs; t.v = v; t.r = r; t.br = b;
    t.e_rdy = er; t.e_bv = ebv; t.e_bresp = ebr;
    t.e_gid = eg; t.e_to = eto; t.e_cnt = ec;
    return t;
  endfunction

  initial begin
    // reset holds everything low even with requests pending
    tbl[0]  = mk(0, 4'hF, 8'h00, 0, 4'h0, 0, 2'd0, 2'd0, 0, 8'd0);
    // single request from index 1
    tbl[1]  = mk(1, 4'h2, 8'h00, 1, 4'h2, 0, 2'd0, 2'd0, 0, 8'd0);
    tbl[2]  = mk(1, 4'h0, 8'h00, 1, 4'h0, 1, 2'd0, 2'd1, 0, 8'd0);
    tbl[3]  = mk(1, 4'h0, 8'h00, 1, 4'h0, 0, 2'd0, 2'd1, 0, 8'd0);
    // fairness after reset: 0,1,2,3,0 back to back
    tbl[4]  = mk(0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 2'd0, 0, 8'd0);
    tbl[5]  = mk(1, 4'hF, 8'hE1, 1, 4'h1, 0, 2'd0, 2'd0, 0, 8'd0);
    tbl[6]  = mk(1, 4'hF, 8'hE1, 1, 4'h2, 1, 2'd1, 2'd0, 0, 8'd0);
    tbl[7]  = mk(1, 4'hF, 8'hE1, 1, 4'h4, 1, 2'd0, 2'd1, 0, 8'd0);
    tbl[8]  = mk(1, 4'hF, 8'hE1, 1, 4'h8, 1, 2'd2, 2'd2, 0, 8'd0);
    tbl[9]  = mk(1, 4'hF, 8'hE1, 1, 4'h1, 1, 2'd3, 2'd3, 0, 8'd1);
    tbl[10] = mk(1, 4'h0, 8'hE1, 1, 4'h0, 1, 2'd1, 2'd0, 0, 8'd2);
    tbl[11] = mk(1, 4'h0, 8'hE1, 1, 4'h0, 0, 2'd1, 2'd0, 0, 8'd2);
    // backpressure with SLVERR, 7 wait cycles
    tbl[12] = mk(0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 2'd0, 0, 8'd0);
    tbl[13] = mk(1, 4'h4, 8'h20, 0, 4'h4, 0, 2'd0, 2'd0, 0, 8'd0);
    for (int i = 14; i <= 18; i++)
      tbl[i] = mk(1, 4'h0, 8'h20, 0, 4'h0, 1, 2'd2, 2'd2, 0, 8'd0);
    tbl[19] = mk(1, 4'h0, 8'h20, 0, 4'h0, 1, 2'd2, 2'd2, 1, 8'd0);
    tbl[20] = mk(1, 4'h0, 8'h20, 0, 4'h0, 1, 2'd2, 2'd2, 1, 8'd0);
    tbl[21] = mk(1, 4'h0, 8'h20, 1, 4'h0, 1, 2'd2, 2'd2, 1, 8'd0);
    tbl[22] = mk(1, 4'h0, 8'h20, 0, 4'h0, 0, 2'd2, 2'd2, 1, 8'd1);
    // withdrawn request 2 while busy; stray BREADY while idle
    tbl[23] = mk(1, 4'h1, 8'h00, 0, 4'h1, 0, 2'd2, 2'd2, 1, 8'd1);
    tbl[24] = mk(1, 4'h4, 8'h00, 0, 4'h0, 1, 2'd0, 2'd0, 1, 8'd1);
    tbl[25] = mk(1, 4'h0, 8'h00, 0, 4'h0, 1, 2'd0, 2'd0, 1, 8'd1);
    tbl[26] = mk(1, 4'h0, 8'h00, 1, 4'h0, 1, 2'd0, 2'd0, 1, 8'd1);
    tbl[27] = mk(1, 4'h0, 8'h00, 1, 4'h0, 0, 2'd0, 2'd0, 1, 8'd1);
    tbl[28] = mk(1, 4'h0, 8'h00, 1, 4'h0, 0, 2'd0, 2'd0, 1, 8'd1);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      rst_n  = tbl[i].rst;
      valid  = tbl[i].v;
      resp   = tbl[i].r;
      bready = tbl[i].br;
      #2;
      check($sformatf("vec%0d rdy/bv/bresp/gid/to/cnt", i),
            32'({ready, bvalid, bresp, gid, to, cnt}),
            32'({tbl[i].e_rdy, tbl[i].e_bv, tbl[i].e_bresp,
                 tbl[i].e_gid, tbl[i].e_to, tbl[i].e_cnt}));
    end

    // reset mid-response drops BVALID without waiting for a clock
    @(negedge clk);
    valid = 4'h1; resp = 8'h02; bready = 1'b0;
    @(negedge clk);
    valid = 4'h0;
    #2;
    check("busy_before_reset bvalid", 32'(bvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset bvalid", 32'(bvalid), 32'd0);
    check("async_reset bresp", 32'(bresp), 32'd0);
    check("async_reset timeout", 32'(to), 32'd0);

    // after release index 0 wins first; BVALID low in that cycle
    @(negedge clk);
    rst_n = 1'b1; valid = 4'hF; resp = 8'hAA; bready = 1'b1;
    #2;
    check("post_reset first grant", 32'(ready), 32'h1);
    check("post_reset bvalid", 32'(bvalid), 32'd0);

    // continuous SLVERR handshakes saturate the counter
    for (int n = 1; n <= 330; n++) begin
      @(negedge clk);
      #2;
      if (n == 101)
        check("slverr_cnt at 100", 32'(cnt), 32'd100);
      if (n == 256)
        check("slverr_cnt at 255", 32'(cnt), 32'd255);
      if (n == 300)
        check("slverr_cnt sat", 32'(cnt), 32'd255);
      if (n == 300)
        check("bvalid back to back", 32'(bvalid), 32'd1);
    end
    check("slverr_cnt holds", 32'(cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
